// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - multiplexed seven-segment bus reader with glitch filter and frame handshake
// Optional decimal-point tracking is enabled by defining SEG7_DP_EN.
module seg7_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg,
    input  logic [DIGITS-1:0]   an,
`ifdef SEG7_DP_EN
    input  logic                dp,
    output logic [DIGITS-1:0]   digit_dp,
    output logic [5*DIGITS-1:0] frame_data,
`else
    output logic [4*DIGITS-1:0] frame_data,
`endif
    output logic [4*DIGITS-1:0] digit_val,
    output logic [DIGITS-1:0]   digit_err,
    output logic                upd,
    output logic [2:0]          upd_idx,
    output logic                frame_valid,
    input  logic                frame_ready
);

`ifdef SEG7_DP_EN
    localparam int SW = 8;
    localparam int FW = 5 * DIGITS;
`else
    localparam int SW = 7;
    localparam int FW = 4 * DIGITS;
`endif
    localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_LOCKED
    } state_t;

    // Registered bus sample; the dp bit (when present) sits above the seven segment bits.
    logic [DIGITS-1:0] r_an_q;
    logic [SW-1:0]     r_smp_q;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [DIGITS-1:0] r_trk_an;
    logic [SW-1:0]     r_trk_smp;
    logic              w_latch;
    logic              w_accept;

    logic              w_valid;
    logic              w_match;
    logic [2:0]        w_idx;
    logic [4:0]        w_dec;
    logic [3:0]        w_dec_val;
    logic              w_dec_err;

    logic [4*DIGITS-1:0] r_digit_val;
    logic [DIGITS-1:0]   r_digit_err;
    logic [4*DIGITS-1:0] w_val_nxt;
    logic [DIGITS-1:0]   w_err_nxt;
    logic [DIGITS-1:0]   w_acc_mask;
    logic                w_changed;
    logic                r_upd;
    logic [2:0]          r_upd_idx;

    logic [DIGITS-1:0] r_captured;
    logic              r_frame_valid;
    logic [FW-1:0]     r_frame_data;
    logic [FW-1:0]     w_frame_nxt;
    logic              w_load;

`ifdef SEG7_DP_EN
    logic [DIGITS-1:0] r_digit_dp;
    logic [DIGITS-1:0] w_dp_nxt;
`endif

    function automatic logic [4:0] f_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0011000: r = {1'b0, 4'h9};
            7'b1111100: r = {1'b1, 4'hE};
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_q  <= '1;
            r_smp_q <= '1;
        end else begin
            r_an_q  <= an;
`ifdef SEG7_DP_EN
            r_smp_q <= {dp, seg};
`else
            r_smp_q <= seg;
`endif
        end
    end

    assign w_valid   = $onehot(~r_an_q);
    assign w_match   = (r_an_q == r_trk_an) && (r_smp_q == r_trk_smp);
    assign w_dec     = f_decode(r_smp_q[6:0]);
    assign w_dec_val = w_dec[3:0];
    assign w_dec_err = w_dec[4];

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!r_an_q[i]) w_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_trk_an  <= '1;
            r_trk_smp <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_trk_an  <= r_an_q;
                r_trk_smp <= r_smp_q;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = S_TRACK;
                    w_cnt_nxt   = 8'd1;
                    w_latch     = 1'b1;
                end
            end
            S_TRACK: begin
                if (!w_valid) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_match) begin
                    w_cnt_nxt = 8'd1;
                    w_latch   = 1'b1;
                end else if (r_cnt >= CNT_LAST) begin
                    // The sample that completes the run is the accept itself.
                    w_state_nxt = S_LOCKED;
                    w_cnt_nxt   = CNT_FULL;
                    w_accept    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_LOCKED: begin
                if (!w_valid) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_match) begin
                    w_state_nxt = S_TRACK;
                    w_cnt_nxt   = 8'd1;
                    w_latch     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_val_nxt  = r_digit_val;
        w_err_nxt  = r_digit_err;
        w_acc_mask = '0;
        w_changed  = 1'b0;
`ifdef SEG7_DP_EN
        w_dp_nxt   = r_digit_dp;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (w_accept && (w_idx == 3'(i))) begin
                w_acc_mask[i] = 1'b1;
                if ((r_digit_val[4*i +: 4] != w_dec_val) || (r_digit_err[i] != w_dec_err))
                    w_changed = 1'b1;
                w_val_nxt[4*i +: 4] = w_dec_val;
                w_err_nxt[i]        = w_dec_err;
`ifdef SEG7_DP_EN
                if (r_digit_dp[i] != r_smp_q[7]) w_changed = 1'b1;
                w_dp_nxt[i] = r_smp_q[7];
`endif
            end
        end
    end

    // Snapshot is built from next-state digits so a same-cycle accept lands in the frame.
    always_comb begin
        w_frame_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG7_DP_EN
            w_frame_nxt[5*i +: 5] = {w_dp_nxt[i], w_val_nxt[4*i +: 4]};
`else
            w_frame_nxt[4*i +: 4] = w_val_nxt[4*i +: 4];
`endif
        end
    end

    assign w_load = (&r_captured) && (!r_frame_valid || frame_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_val <= '1;
            r_digit_err <= '1;
            r_upd       <= 1'b0;
            r_upd_idx   <= '0;
`ifdef SEG7_DP_EN
            r_digit_dp  <= '1;
`endif
        end else begin
            r_digit_val <= w_val_nxt;
            r_digit_err <= w_err_nxt;
            r_upd       <= w_accept && w_changed;
            if (w_accept && w_changed) r_upd_idx <= w_idx;
`ifdef SEG7_DP_EN
            r_digit_dp  <= w_dp_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_captured    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '1;
        end else begin
            if (w_load) begin
                r_captured    <= '0;
                r_frame_valid <= 1'b1;
                r_frame_data  <= w_frame_nxt;
            end else begin
                r_captured <= r_captured | w_acc_mask;
                if (r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
            end
        end
    end

    assign digit_val   = r_digit_val;
    assign digit_err   = r_digit_err;
    assign upd         = r_upd;
    assign upd_idx     = r_upd_idx;
    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
`ifdef SEG7_DP_EN
    assign digit_dp    = r_digit_dp;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - directed bench with run-length reference model for seg7_scan_reader
module tb_seg7_scan_reader;
    localparam int D = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [6:0]     seg = 7'h7F;
    logic [D-1:0]   an = '1;
    logic           frame_ready = 1'b0;
    logic [4*D-1:0] digit_val;
    logic [4*D-1:0] frame_data;
    logic [D-1:0]   digit_err;
    logic           upd;
    logic [2:0]     upd_idx;
    logic           frame_valid;

    always #5 clk = ~clk;

    seg7_scan_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digit_val   (digit_val),
        .digit_err   (digit_err),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    int u0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    function automatic logic [4:0] m_decode(input logic [6:0] s);
        if (s == 7'b1111100) return {1'b1, 4'hE};
        for (int v = 0; v < 10; v++)
            if (glyph[v] == s) return {1'b0, 4'(v)};
        return {1'b1, 4'hF};
    endfunction

    // Reference: a digit is accepted one edge after its input run length reaches S.
    logic [3:0]     m_val [D];
    logic           m_err [D];
    logic [D-1:0]   m_cap;
    logic           m_fv;
    logic [4*D-1:0] m_fd;
    logic           m_upd;
    logic [2:0]     m_idx;
    logic [D-1:0]   prev_an;
    logic [6:0]     prev_seg;
    int             run_len;
    logic           pend;
    int             pend_idx;
    logic [6:0]     pend_seg;
    logic           m_load;
    logic [4:0]     m_d;
    logic           m_vs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                m_val[i] = 4'hF;
                m_err[i] = 1'b1;
            end
            m_cap = '0; m_fv = 1'b0; m_fd = '1; m_upd = 1'b0; m_idx = '0;
            prev_an = '1; prev_seg = '1; run_len = 0; pend = 1'b0; pend_idx = 0; pend_seg = '1;
        end else begin
            m_load = (&m_cap) && (!m_fv || frame_ready);
            m_upd = 1'b0;
            if (pend) begin
                m_d = m_decode(pend_seg);
                if (m_d[3:0] != m_val[pend_idx] || m_d[4] != m_err[pend_idx]) begin
                    m_upd = 1'b1;
                    m_idx = 3'(pend_idx);
                end
                m_val[pend_idx] = m_d[3:0];
                m_err[pend_idx] = m_d[4];
            end
            if (m_load) begin
                for (int i = 0; i < D; i++) m_fd[4*i +: 4] = m_val[i];
                m_fv = 1'b1;
                m_cap = '0;
            end else begin
                if (m_fv && frame_ready) m_fv = 1'b0;
                if (pend) m_cap[pend_idx] = 1'b1;
            end
            m_vs = ($countones(~an) == 1);
            if (!m_vs) run_len = 0;
            else if (run_len > 0 && an == prev_an && seg == prev_seg) run_len++;
            else run_len = 1;
            prev_an = an;
            prev_seg = seg;
            pend = m_vs && (run_len == S);
            for (int i = 0; i < D; i++) if (!an[i]) pend_idx = i;
            pend_seg = seg;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < D; i++) begin
                chk("digit_val", 32'(digit_val[4*i +: 4]), 32'(m_val[i]));
                chk("digit_err", 32'(digit_err[i]), 32'(m_err[i]));
            end
            chk("upd", 32'(upd), 32'(m_upd));
            if (m_upd) chk("upd_idx", 32'(upd_idx), 32'(m_idx));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("frame_data", 32'(frame_data), 32'(m_fd));
            if (upd) upd_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int idx, input logic [6:0] s, input int n);
        an = ~(D'(1) << idx);
        seg = s;
        step(n);
    endtask

    task automatic idle(input int n);
        an = '1;
        seg = 7'h7F;
        step(n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digit_val"}, 32'(digit_val), 32'(16'hFFFF));
        chk({tag, "_digit_err"}, 32'(digit_err), 32'(4'hF));
        chk({tag, "_upd"}, 32'(upd), 32'd0);
        chk({tag, "_upd_idx"}, 32'(upd_idx), 32'd0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        chk({tag, "_frame_data"}, 32'(frame_data), 32'(16'hFFFF));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step(3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        idle(3);

        // Run one sample short of the threshold, then break it.
        drive(0, 7'b0000010, S - 1);
        drive(0, 7'b1111111, 1);
        idle(6);
        chk("short_run_digit0", 32'(digit_val[3:0]), 32'hF);
        chk("short_run_upd", 32'(upd_cnt), 32'd0);

        an = 4'b1100;
        seg = 7'b0100100;
        step(20);
        idle(4);
        chk("two_low_digits", 32'(digit_val), 32'(16'hFFFF));
        chk("two_low_upd", 32'(upd_cnt), 32'd0);

        u0 = upd_cnt;
        drive(0, 7'b0100100, 8);
        drive(1, 7'b1111001, 8);
        drive(2, 7'b0110000, 8);
        drive(3, 7'b0011001, 8);
        idle(2);
        chk("frame1_valid", 32'(frame_valid), 32'd1);
        chk("frame1_data", 32'(frame_data), 32'(16'h4312));
        chk("frame1_upd_count", 32'(upd_cnt - u0), 32'd4);

        drive(2, 7'b1111100, 8);
        drive(3, 7'b0000001, 8);
        idle(2);
        chk("errglyph_val", 32'(digit_val[11:8]), 32'hE);
        chk("errglyph_err", 32'(digit_err[2]), 32'd1);
        chk("badglyph_val", 32'(digit_val[15:12]), 32'hF);
        chk("badglyph_err", 32'(digit_err[3]), 32'd1);

        drive(0, 7'b1111000, 8);
        drive(1, 7'b0011000, 8);
        idle(2);
        chk("held_frame_data", 32'(frame_data), 32'(16'h4312));
        chk("held_frame_valid", 32'(frame_valid), 32'd1);
        chk("frame2_digits", 32'(digit_val), 32'(16'hFE97));
        frame_ready = 1'b1;
        step(1);
        frame_ready = 1'b0;
        chk("b2b_frame_valid", 32'(frame_valid), 32'd1);
        chk("b2b_frame_data", 32'(frame_data), 32'(16'hFE97));

        drive(0, 7'b0000000, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step(2);
        rst_n = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the BCD-to-seven-segment decoder. It monitors a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables), filters scan-transition glitches, decodes each stable segment pattern back to a 4-bit digit value, and assembles complete display frames. Complete frames go to downstream logic through a valid/ready handshake. Used for display loopback self-test and for reading displays driven by external boards.

## Interface
Parameters:
- DIGITS, 4: number of multiplexed digits/anodes (1..8).
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a digit (2..255).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}.
- an  in  DIGITS  anode enables, active-low, one-hot-low when driving.
- digit_val  out  4*DIGITS  decoded values; digit i at [4i+3:4i].
- digit_err  out  DIGITS  per-digit flag: last accepted pattern was not a numeral.
- upd  out  1  one-cycle pulse on any accepted digit whose value or err changed.
- upd_idx  out  3  index of the digit for upd; valid only while upd=1.
- frame_valid  out  1  a complete frame is held in frame_data.
- frame_ready  in  1  consumer accepts the frame.
- frame_data  out  4*DIGITS  frame snapshot, same packing as digit_val.

## Operation
- Decode table (seg -> value): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9.
- 1111100 (error glyph) -> value 4'hE, err=1. Any other pattern -> value 4'hF, err=1. Decoding is combinational and only used internally.
- Sample qualification: a sample is valid only when exactly one bit of `an` is 0. No anode low, or several low, is an idle sample.
- Filter FSM states:
  - IDLE -> TRACK on a valid sample. The tracked (an, seg) pair is latched and cnt=1.
  - TRACK: a matching sample gives cnt+1. A different valid sample relatches the pair with cnt=1. An idle sample returns to IDLE.
  - TRACK -> LOCKED when cnt reaches STABLE_CYCLES, on the same cycle the final sample is counted. That cycle is the accept.
  - LOCKED: matching samples cause no action. A different valid sample goes to TRACK with cnt=1. An idle sample goes to IDLE.
  - cnt saturates and never wraps.
- Accept action for digit i = index of the low anode:
  - write digit_val[i] and digit_err[i];
  - set captured[i];
  - pulse upd with upd_idx=i only if value or err differs from the stored entry.
- Frame assembly:
  - When captured is all-ones and frame_valid=0: copy digit_val (including the same-cycle accept) into frame_data, set frame_valid, clear captured.
  - frame_data is stable while frame_valid=1.
  - Handshake completes on a cycle with frame_valid & frame_ready; frame_valid drops the next cycle.
  - Accepts during frame_valid=1 still update digit_val and captured. They count toward the next frame.
- Simultaneous handshake and all-captured on the same cycle: frame_valid stays 1 and frame_data reloads. This gives back-to-back frames.

## Timing
- Reset values: digit_val all 4'hF, digit_err all 1, upd=0, upd_idx=0, frame_valid=0, frame_data all 4'hF, FSM IDLE, cnt=0, captured=0.
- Inputs are registered once before the filter.
- Accept latency: for a pattern first present at input edge k, digit_val updates at edge k+STABLE_CYCLES, and upd is high in the following cycle.
- frame_valid rises the edge after the accept that completes the frame.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any pending frame is discarded.

## Configuration
- SEG7_DP_EN defined:
  - adds input `dp` (1 bit, active-low) and output `digit_dp` (DIGITS bits);
  - `dp` is part of the tracked pair and is stored per digit on accept;
  - frame_data widens to 5*DIGITS, packed {dp,val} per digit;
  - a dp change alone triggers upd.
- Undefined: no dp ports, and the decimal point is ignored.

## Test plan
- Reset, then scan an=1110/seg=0100100, an=1101/1111001, an=1011/0110000, an=0111/0011001, each held 8 cycles -> frame_valid=1, frame_data=16'h4312, four upd pulses.
- Hold an=1110/seg=0000010 for STABLE_CYCLES-1 cycles, then change seg -> no accept, digit 0 stays 4'hF.
- Drive an=1100 (two low) with a valid seg for 20 cycles -> no accepts, FSM stays IDLE.
- Accept 1111100 on digit 2, then seg=0000001 on digit 3 -> digit_err[2]=1 with val 4'hE, digit_err[3]=1 with val 4'hF.
- Keep frame_ready=0 while scanning a second full frame -> frame_data holds the first frame. Raise frame_ready -> handshake, second frame loads back-to-back.
- Assert rst_n=0 mid-TRACK with frame_valid=1 -> all outputs return to reset values on the same cycle.
